// File: rtl/flit_sink_pkg.sv
// Shared types and constants for the flit sink. Supplies the constants_2D.v values
// (`SIZE, `NUM_NODES) behind their guard.
`ifndef CONSTANTS_2D_V
`define CONSTANTS_2D_V
`define SIZE 8
`define NUM_NODES 16
`endif

package flit_sink_pkg;

  localparam int unsigned FLIT_W   = `SIZE;
  localparam int unsigned RX_CNT_W = 16;

  typedef logic [FLIT_W-1:0]   flit_t;
  typedef logic [RX_CNT_W-1:0] rx_cnt_t;

  localparam rx_cnt_t RX_CNT_MAX = 16'hFFFF;

  function automatic rx_cnt_t sat_inc(input rx_cnt_t v);
    return (v == RX_CNT_MAX) ? v : v + rx_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sink_fifo.sv
// DEPTH x FLIT_W FIFO for the flit sink; pointers wrap modulo DEPTH so DEPTH need
// not be a power of two.
module sink_fifo
  import flit_sink_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [FLIT_W-1:0] i_data,
  output logic [FLIT_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees the slot the same-edge push lands in when full.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/flit_sink.sv
// Terminal flit consumer: buffers ejected flits, drains them at a fixed service rate and
// keeps delivery statistics. Define SINK_CHECK_EN to build the destination check.
module flit_sink
  import flit_sink_pkg::*;
#(
  parameter int unsigned id           = 0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DRAIN_PERIOD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [FLIT_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_flit_valid,
  output logic [FLIT_W-1:0] o_flit_out,
  output logic [15:0]       o_rx_count,
  output logic              o_overflow,
  output logic              o_misroute
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DRN_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  if (DEPTH < 2 || DRAIN_PERIOD < 1 || id >= (1 << FLIT_W)) begin : g_param_err
    $error("flit_sink: parameter out of range");
  end

  logic [FLIT_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drain_tc;
  logic [DRN_W-1:0]  w_drain_d;

  logic [DRN_W-1:0]  r_drain_cnt;
  logic              r_flit_valid;
  logic [FLIT_W-1:0] r_flit_out;
  rx_cnt_t           r_rx_count;
  logic              r_overflow;

  sink_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // One spare slot below full covers the single req upstream may issue after busy rises.
  assign o_busy     = (w_count >= CNT_W'(DEPTH - 1));
  assign w_drain_tc = (r_drain_cnt == DRN_W'(DRAIN_PERIOD - 1));
  assign w_pop      = !w_empty && w_drain_tc;
  assign w_push     = i_req && (!w_full || w_pop);

  always_comb begin
    w_drain_d = r_drain_cnt + DRN_W'(1);
    if (w_empty || w_drain_tc) begin
      w_drain_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drain_cnt  <= '0;
      r_flit_valid <= 1'b0;
      r_flit_out   <= '0;
      r_rx_count   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_drain_cnt  <= w_drain_d;
      r_flit_valid <= w_pop;
      if (w_pop)  r_flit_out <= w_head;
      if (w_push) r_rx_count <= sat_inc(r_rx_count);
      if (i_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_flit_valid = r_flit_valid;
  assign o_flit_out   = r_flit_out;
  assign o_rx_count   = r_rx_count;
  assign o_overflow   = r_overflow;

`ifdef SINK_CHECK_EN
  logic w_bad_dest;
  logic r_misroute;

  assign w_bad_dest = w_pop && (w_head != FLIT_W'(id));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misroute <= 1'b0;
    end else if (w_bad_dest) begin
      r_misroute <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_bad_dest) begin
      $display("[flit_sink] t=%0t id=%0d misrouted flit=%0h", $time, id, w_head);
    end
  end

  assign o_misroute = r_misroute;
`else
  assign o_misroute = 1'b0;
`endif

endmodule

// File: tb/tb_flit_sink.sv
// Bench for flit_sink: three instances (drain periods 1, 4, 8) sharing clock and reset,
// each with an expected-flit queue checked whenever flit_valid pulses.
module tb_flit_sink;
  import flit_sink_pkg::*;

`ifdef SINK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req   [3];
  logic [FLIT_W-1:0] data  [3];
  logic              busy  [3];
  logic              valid [3];
  logic [FLIT_W-1:0] fout  [3];
  logic [15:0]       rx    [3];
  logic              ovf   [3];
  logic              mis   [3];

  flit_t sbq [3][$];
  int    pops [3];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_pop1 = -1;
  bit    ivl_en  = 1'b0;

  flit_sink #(.id(2), .DEPTH(4), .DRAIN_PERIOD(1)) u_dut0 (
    .clk(clk), .reset(reset), .i_req(req[0]), .i_data(data[0]), .o_busy(busy[0]),
    .o_flit_valid(valid[0]), .o_flit_out(fout[0]), .o_rx_count(rx[0]),
    .o_overflow(ovf[0]), .o_misroute(mis[0])
  );
  flit_sink #(.id(2), .DEPTH(4), .DRAIN_PERIOD(4)) u_dut1 (
    .clk(clk), .reset(reset), .i_req(req[1]), .i_data(data[1]), .o_busy(busy[1]),
    .o_flit_valid(valid[1]), .o_flit_out(fout[1]), .o_rx_count(rx[1]),
    .o_overflow(ovf[1]), .o_misroute(mis[1])
  );
  flit_sink #(.id(2), .DEPTH(4), .DRAIN_PERIOD(8)) u_dut2 (
    .clk(clk), .reset(reset), .i_req(req[2]), .i_data(data[2]), .o_busy(busy[2]),
    .o_flit_valid(valid[2]), .o_flit_out(fout[2]), .o_rx_count(rx[2]),
    .o_overflow(ovf[2]), .o_misroute(mis[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 3; i++) begin
      sbq[i].delete();
      pops[i] = 0;
    end
    last_pop1 = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_sb();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every pop must match the oldest flit the bench expects to have been accepted.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (valid[i]) begin
          pops[i]++;
          if (sbq[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb%0d_unexpected_pop actual=%0h required=none", i, fout[i]);
          end else begin
            check($sformatf("sb%0d_flit", i), 32'(fout[i]), 32'(sbq[i].pop_front()));
          end
        end
      end
      if (ivl_en && valid[1]) begin
        if (last_pop1 >= 0) check("t2_pop_interval", 32'(cyc - last_pop1), 32'd4);
        last_pop1 = cyc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic              req;
    logic [FLIT_W-1:0] data;
    logic              exp_busy;
    logic [15:0]       exp_rx;
  } vec_t;

  vec_t  t1 [7];
  flit_t t5 [3];
  int    sent;
  int    first_busy_sent;

  initial begin
    for (int i = 0; i < 7; i++) begin
      t1[i].req      = (i < 5);
      t1[i].data     = FLIT_W'(8'h10 + i);
      t1[i].exp_busy = 1'b0;
      t1[i].exp_rx   = 16'((i < 5) ? i + 1 : 5);
    end
    t5[0] = FLIT_W'(2);
    t5[1] = FLIT_W'(2);
    t5[2] = FLIT_W'(5);

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i]  = 1'b0;
      data[i] = '0;
    end
    clear_sb();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d_busy", i), 32'(busy[i]), 0);
      check($sformatf("rst%0d_valid", i), 32'(valid[i]), 0);
      check($sformatf("rst%0d_flit_out", i), 32'(fout[i]), 0);
      check($sformatf("rst%0d_rx_count", i), 32'(rx[i]), 0);
      check($sformatf("rst%0d_overflow", i), 32'(ovf[i]), 0);
      check($sformatf("rst%0d_misroute", i), 32'(mis[i]), 0);
    end
    reset = 1'b0;
    tick();

    // Destination check: only the third flit (5) differs from id=2.
    for (int i = 0; i < 3; i++) begin
      req[0] = 1'b1;
      data[0] = t5[i];
      sbq[0].push_back(t5[i]);
      tick();
      req[0] = 1'b0;
      tick();
      tick();
      check($sformatf("t5_misroute_%0d", i), 32'(mis[0]), 32'(CheckEn && i == 2));
    end
    tick();
    check("t5_misroute_sticky", 32'(mis[0]), 32'(CheckEn));

    do_reset();

    // Five back-to-back flits at one pop per cycle never build up enough to assert busy.
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_busy_pre_%0d", i), 32'(busy[0]), 32'(t1[i].exp_busy));
      req[0]  = t1[i].req;
      data[0] = t1[i].data;
      if (t1[i].req) sbq[0].push_back(t1[i].data);
      tick();
      req[0] = 1'b0;
      check($sformatf("t1_rx_%0d", i), 32'(rx[0]), 32'(t1[i].exp_rx));
    end
    tick();
    check("t1_overflow", 32'(ovf[0]), 0);
    check("t1_all_popped", 32'(sbq[0].size()), 0);
    check("t1_pop_count", 32'(pops[0]), 5);

    // Busy-honouring source against a 1-in-4 drain.
    ivl_en = 1'b1;
    sent = 0;
    first_busy_sent = -1;
    for (int c = 0; c < 200 && sent < 10; c++) begin
      if (busy[1] && first_busy_sent < 0) first_busy_sent = sent;
      if (!busy[1]) begin
        req[1]  = 1'b1;
        data[1] = FLIT_W'(8'h20 + sent);
        sbq[1].push_back(data[1]);
        sent++;
      end else begin
        req[1] = 1'b0;
      end
      tick();
    end
    req[1] = 1'b0;
    check("t2_sent", 32'(sent), 10);
    check("t2_busy_at_count3", 32'(first_busy_sent), 3);
    for (int c = 0; c < 50; c++) tick();
    ivl_en = 1'b0;
    check("t2_rx_count", 32'(rx[1]), 10);
    check("t2_overflow", 32'(ovf[1]), 0);
    check("t2_pop_count", 32'(pops[1]), 10);
    check("t2_all_popped", 32'(sbq[1].size()), 0);

    // Fill to full; the fifth req lands on the edge where the first pop is due.
    for (int i = 0; i < 5; i++) begin
      req[1]  = 1'b1;
      data[1] = FLIT_W'(8'h50 + i);
      sbq[1].push_back(data[1]);
      tick();
    end
    req[1] = 1'b0;
    check("t4_pop_same_edge", 32'(valid[1]), 1);
    check("t4_rx_count", 32'(rx[1]), 15);
    check("t4_overflow", 32'(ovf[1]), 0);
    check("t4_busy", 32'(busy[1]), 1);
    for (int c = 0; c < 4; c++) tick();
    check("t4_count_held", 32'(busy[1]), 1);
    for (int c = 0; c < 30; c++) tick();
    check("t4_all_popped", 32'(sbq[1].size()), 0);

    // Slow drain with req every cycle: the fifth flit finds the FIFO full.
    for (int i = 0; i < 5; i++) begin
      req[2]  = 1'b1;
      data[2] = FLIT_W'(8'h30 + i);
      if (i < 4) sbq[2].push_back(data[2]);
      tick();
      if (i == 3) begin
        check("t3_overflow_pre", 32'(ovf[2]), 0);
        check("t3_busy_full", 32'(busy[2]), 1);
      end
    end
    req[2] = 1'b0;
    check("t3_overflow", 32'(ovf[2]), 1);
    check("t3_rx_count", 32'(rx[2]), 4);
    for (int c = 0; c < 40; c++) tick();
    check("t3_pop_count", 32'(pops[2]), 4);
    check("t3_all_popped", 32'(sbq[2].size()), 0);

    // Asynchronous reset with three flits buffered.
    for (int i = 0; i < 3; i++) begin
      req[2]  = 1'b1;
      data[2] = FLIT_W'(8'h40 + i);
      sbq[2].push_back(data[2]);
      tick();
    end
    req[2] = 1'b0;
    check("t6_busy_pre", 32'(busy[2]), 1);
    check("t6_rx_pre", 32'(rx[2]), 7);
    #2;
    reset = 1'b1;
    #1;
    check("t6_busy_async", 32'(busy[2]), 0);
    check("t6_valid_async", 32'(valid[2]), 0);
    check("t6_rx_async", 32'(rx[2]), 0);
    check("t6_overflow_async", 32'(ovf[2]), 0);
    clear_sb();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("t6_no_stale_pop", 32'(pops[2]), 0);
    check("t6_rx_after", 32'(rx[2]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
